// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory stage: FSM encoding, address layout and defaults.
package dm_pkg;
  localparam int WORD_BYTES    = 4;
  localparam int ADDR_LSB      = $clog2(WORD_BYTES);
  localparam int DEPTH_DEFAULT = 256;
  localparam int LAT_DEFAULT   = 1;
  localparam int CNT_W         = 4;

  typedef enum logic {
    DM_IDLE = 1'b0,
    DM_WAIT = 1'b1
  } dm_state_e;
endpackage

// File: rtl/dm_word_ram.sv
// Single-port synchronous word RAM with registered read; contents are never cleared.
module dm_word_ram
  import dm_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dm_stage_unit.sv
// Data-memory pipeline stage: latency FSM, stall generation and DM/WB output registers.
// Optional macro DM_TRACE_EN prints every completed access.
module dm_stage_unit
  import dm_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int LAT   = LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] mem_address_in,
  input  logic [31:0] write_data_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic [4:0]  rd_in,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic        stall_out,
  output logic        misalign_out
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LAT > 1) ? CNT_W'(LAT - 2) : '0;

  // Handshake: while stall_out is high the upstream EX/DM register holds every
  // *_in signal stable; the access completes on the first edge where stall_out is low.
  dm_state_e        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             req, aligned;
  logic             fire, bubble, stall_c, misalign_c;
  logic             load_q;
  logic             ram_we, ram_re;
  logic [31:0]      ram_rdata;
  logic [IDX_W-1:0] idx;

  assign req     = mem_read_in | mem_write_in;
  assign aligned = (mem_address_in[ADDR_LSB-1:0] == '0);
  assign idx     = mem_address_in[IDX_W+ADDR_LSB-1:ADDR_LSB];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DM_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    fire       = 1'b0;
    bubble     = 1'b0;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    case (state)
      DM_IDLE: begin
        if (req && !aligned) begin
          misalign_c = 1'b1;
        end else if (req) begin
          if (LAT == 1) begin
            fire = 1'b1;
          end else begin
            stall_c    = 1'b1;
            bubble     = 1'b1;
            state_next = DM_WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      DM_WAIT: begin
        if (cnt != '0) begin
          stall_c  = 1'b1;
          bubble   = 1'b1;
          cnt_next = cnt - 1'b1;
        end else begin
          fire       = 1'b1;
          state_next = DM_IDLE;
        end
      end
      default: state_next = DM_IDLE;
    endcase
  end

  // Reset suppresses both the stall and any memory write, which aborts an access in flight.
  assign stall_out = stall_c & ~reset;
  assign ram_we    = fire & mem_write_in & ~reset;
  assign ram_re    = fire & mem_read_in & ~mem_write_in;

  dm_word_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (idx),
    .wdata (write_data_in),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_out <= '0;
      rd_out         <= '0;
      mem_to_reg_out <= 1'b0;
      reg_write_out  <= 1'b0;
      misalign_out   <= 1'b0;
      load_q         <= 1'b0;
    end else begin
      alu_result_out <= mem_address_in;
      rd_out         <= rd_in;
      mem_to_reg_out <= mem_to_reg_in;
      reg_write_out  <= reg_write_in & ~bubble & ~misalign_c;
      misalign_out   <= misalign_c;
      load_q         <= ram_re;
    end
  end

  // The RAM read port is registered, so load_q marks the cycle its data is valid.
  assign read_data_out = load_q ? ram_rdata : '0;

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && fire && mem_write_in)
      $display("%0t dm W addr=%h data=%h rd=%0d", $time, mem_address_in, write_data_in, rd_in);
    if (!reset && load_q)
      $display("%0t dm R addr=%h data=%h rd=%0d", $time, alu_result_out, ram_rdata, rd_out);
  end
`endif

endmodule

// File: tb/tb_dm_stage_unit.sv
// Bench for dm_stage_unit: a LAT=1 and a LAT=4 instance, each checked every cycle against a
// transaction-level model (memory array plus per-request cycle count).
module tb_dm_stage_unit;

  localparam int DEPTH = 256;
  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        mr [2];
  logic        mw [2];
  logic [31:0] ma [2];
  logic [31:0] wd [2];
  logic        mtr[2];
  logic        rw [2];
  logic [4:0]  rdn[2];

  logic [31:0] o_rdata[2];
  logic [31:0] o_alu  [2];
  logic [4:0]  o_rd   [2];
  logic        o_mtr  [2];
  logic        o_rw   [2];
  logic        o_stl  [2];
  logic        o_mis  [2];

  dm_stage_unit #(.DEPTH(DEPTH), .LAT(LAT_A)) dut_a (
    .clk(clk), .reset(reset),
    .mem_read_in(mr[0]), .mem_write_in(mw[0]), .mem_address_in(ma[0]),
    .write_data_in(wd[0]), .mem_to_reg_in(mtr[0]), .reg_write_in(rw[0]), .rd_in(rdn[0]),
    .read_data_out(o_rdata[0]), .alu_result_out(o_alu[0]), .rd_out(o_rd[0]),
    .mem_to_reg_out(o_mtr[0]), .reg_write_out(o_rw[0]), .stall_out(o_stl[0]),
    .misalign_out(o_mis[0])
  );

  dm_stage_unit #(.DEPTH(DEPTH), .LAT(LAT_B)) dut_b (
    .clk(clk), .reset(reset),
    .mem_read_in(mr[1]), .mem_write_in(mw[1]), .mem_address_in(ma[1]),
    .write_data_in(wd[1]), .mem_to_reg_in(mtr[1]), .reg_write_in(rw[1]), .rd_in(rdn[1]),
    .read_data_out(o_rdata[1]), .alu_result_out(o_alu[1]), .rd_out(o_rd[1]),
    .mem_to_reg_out(o_mtr[1]), .reg_write_out(o_rw[1]), .stall_out(o_stl[1]),
    .misalign_out(o_mis[1])
  );

  function automatic int lat(input int g);
    return (g == 0) ? LAT_A : LAT_B;
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] mmem   [2][DEPTH];
  int          pend   [2];
  logic [31:0] e_rdata[2];
  logic [31:0] e_alu  [2];
  logic [4:0]  e_rd   [2];
  logic        e_mtr  [2];
  logic        e_rw   [2];
  logic        e_mis  [2];

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int unsigned w;
      int          p;
      w = (ma[g] >> 2) % DEPTH;
      if (reset) begin
        e_rdata[g] <= '0; e_alu[g] <= '0; e_rd[g] <= '0;
        e_mtr[g] <= 1'b0; e_rw[g] <= 1'b0; e_mis[g] <= 1'b0;
        pend[g] <= 0;
      end else begin
        e_alu[g]   <= ma[g];
        e_rd[g]    <= rdn[g];
        e_mtr[g]   <= mtr[g];
        e_rdata[g] <= '0;
        e_mis[g]   <= 1'b0;
        e_rw[g]    <= rw[g];
        if (mr[g] || mw[g]) begin
          if (ma[g][1:0] != 2'b00) begin
            e_mis[g] <= 1'b1;
            e_rw[g]  <= 1'b0;
            pend[g]  <= 0;
          end else begin
            p = pend[g] + 1;
            if (p == lat(g)) begin
              pend[g] <= 0;
              if (mw[g]) mmem[g][w] <= wd[g];
              else       e_rdata[g] <= mmem[g][w];
            end else begin
              pend[g] <= p;
              e_rw[g] <= 1'b0;
            end
          end
        end else begin
          pend[g] <= 0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d(LAT=%0d) t=%0t: got %h expected %h", nm, g, lat(g), $time, act, exp);
  endtask

  task automatic compare_all();
    for (int g = 0; g < 2; g++) begin
      logic s;
      s = !reset && (mr[g] || mw[g]) && (ma[g][1:0] == 2'b00) && (pend[g] + 1 < lat(g));
      chk("read_data", g, o_rdata[g], e_rdata[g]);
      chk("alu_result", g, o_alu[g], e_alu[g]);
      chk("rd", g, 32'(o_rd[g]), 32'(e_rd[g]));
      chk("mem_to_reg", g, 32'(o_mtr[g]), 32'(e_mtr[g]));
      chk("reg_write", g, 32'(o_rw[g]), 32'(e_rw[g]));
      chk("misalign", g, 32'(o_mis[g]), 32'(e_mis[g]));
      chk("stall", g, 32'(o_stl[g]), 32'(s));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic set_in(input int g, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic m2r, input logic regw, input logic [4:0] rdv);
    mr[g] = r; mw[g] = w; ma[g] = a; wd[g] = d; mtr[g] = m2r; rw[g] = regw; rdn[g] = rdv;
  endtask

  task automatic idle(input int g);
    set_in(g, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
  endtask

  // Presents one request for its full duration, then returns the input bus to idle.
  task automatic txn(input int g, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic m2r, input logic regw, input logic [4:0] rdv);
    int n;
    set_in(g, r, w, a, d, m2r, regw, rdv);
    n = ((r || w) && a[1:0] == 2'b00) ? lat(g) : 1;
    for (int i = 0; i < n; i++) cycle();
    idle(g);
  endtask

  int pool[8] = '{0, 2, 4, 8, 17, 63, 128, 255};
  logic [31:0] pool_val[2][8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stalls;
    logic s;
    reset = 1'b1;
    idle(0); idle(1);
    repeat (2) @(posedge clk);
    #1;
    cycle();
    for (int g = 0; g < 2; g++) begin
      chk("reset_rdata", g, o_rdata[g], 32'h0);
      chk("reset_alu", g, o_alu[g], 32'h0);
      chk("reset_rw", g, 32'(o_rw[g]), 32'h0);
    end
    reset = 1'b0;

    for (int g = 0; g < 2; g++)
      for (int k = 0; k < 8; k++) begin
        pool_val[g][k] = $urandom;
        txn(g, 1'b0, 1'b1, 32'(pool[k] * 4), pool_val[g][k], 1'b0, 1'b0, 5'd0);
      end

    // Reset with a store pending must not write memory or stall.
    reset = 1'b1;
    for (int g = 0; g < 2; g++) set_in(g, 1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd3);
    cycle();
    cycle();
    for (int g = 0; g < 2; g++) begin
      chk("rst_hold_stall", g, 32'(o_stl[g]), 32'h0);
      chk("rst_hold_rd", g, 32'(o_rd[g]), 32'h0);
      idle(g);
    end
    reset = 1'b0;
    for (int g = 0; g < 2; g++) begin
      txn(g, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd1);
      chk("rst_mem_kept", g, o_rdata[g], pool_val[g][2]);
    end

    // LAT=1 store then load.
    txn(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0);
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd5);
    chk("lat1_load", 0, o_rdata[0], 32'hDEAD_BEEF);
    chk("lat1_rd", 0, 32'(o_rd[0]), 32'd5);
    chk("lat1_rw", 0, 32'(o_rw[0]), 32'd1);

    // LAT=4 load: count stall cycles with inputs held.
    txn(1, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 1'b0, 5'd0);
    set_in(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 5'd9);
    stalls = 0;
    s = 1'b1;
    for (int i = 0; i < 8 && s; i++) begin
      @(negedge clk);
      compare_all();
      s = o_stl[1];
      if (s) begin
        stalls++;
        chk("lat4_bubble_rw", 1, 32'(o_rw[1]), 32'h0);
      end
      @(posedge clk);
      #1;
    end
    idle(1);
    chk("lat4_stall_cycles", 1, 32'(stalls), 32'd3);
    chk("lat4_load", 1, o_rdata[1], 32'hCAFE_F00D);
    chk("lat4_rw", 1, 32'(o_rw[1]), 32'd1);

    // Misaligned requests: single pulse, no write.
    for (int g = 0; g < 2; g++) begin
      txn(g, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b1, 5'd7);
      chk("mis_pulse", g, 32'(o_mis[g]), 32'd1);
      chk("mis_rw", g, 32'(o_rw[g]), 32'd0);
      cycle();
      chk("mis_clear", g, 32'(o_mis[g]), 32'd0);
    end
    txn(1, 1'b0, 1'b1, 32'h22, 32'h0BAD_0BAD, 1'b0, 1'b0, 5'd0);
    txn(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 5'd2);
    chk("mis_store_dropped", 1, o_rdata[1], 32'hCAFE_F00D);

    // Address wrap modulo DEPTH words.
    txn(0, 1'b0, 1'b1, 32'h400, 32'h1234, 1'b0, 1'b0, 5'd0);
    txn(0, 1'b1, 1'b0, 32'h000, 32'h0, 1'b1, 1'b1, 5'd4);
    chk("wrap_load", 0, o_rdata[0], 32'h1234);

    // Reset one cycle into a LAT=4 store aborts it.
    txn(1, 1'b0, 1'b1, 32'h8, 32'hAAAA, 1'b0, 1'b0, 5'd0);
    set_in(1, 1'b0, 1'b1, 32'h8, 32'h55, 1'b0, 1'b0, 5'd0);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle(1);
    cycle();
    txn(1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b1, 5'd6);
    chk("rst_wait_abort", 1, o_rdata[1], 32'hAAAA);

    // Read and write together: store wins, no load data.
    txn(1, 1'b1, 1'b1, 32'h20, 32'h77, 1'b1, 1'b1, 5'd8);
    chk("rw_both_rdata", 1, o_rdata[1], 32'h0);
    txn(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 5'd8);
    chk("rw_both_stored", 1, o_rdata[1], 32'h77);

    // Randomized traffic on both instances.
    for (int t = 0; t < 300; t++) begin
      int g, op, k;
      logic [31:0] a;
      g  = $urandom_range(0, 1);
      op = $urandom_range(0, 4);
      k  = $urandom_range(0, 7);
      a  = {22'($urandom), 8'(pool[k]), 2'b00};
      case (op)
        0: txn(g, 1'b0, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom), 5'($urandom));
        1: txn(g, 1'b1, 1'b0, a, $urandom, 1'($urandom), 1'($urandom), 5'($urandom));
        2: txn(g, 1'b0, 1'b1, a, $urandom, 1'($urandom), 1'($urandom), 5'($urandom));
        3: txn(g, 1'b1, 1'b1, a, $urandom, 1'($urandom), 1'($urandom), 5'($urandom));
        default: txn(g, 1'($urandom), 1'b1, a | 32'($urandom_range(1, 3)), $urandom,
                     1'($urandom), 1'($urandom), 5'($urandom));
      endcase
    end
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dm_stage_unit.md
Name: dm_stage_unit

Overview:
- Data-memory stage: consumer end of the EX/DM pipeline register.
- Takes registered memory controls, address and store data, and performs the word access on an internal data memory.
- Produces the DM/WB-bound result bundle: load data, ALU result, rd, writeback controls.
- Models configurable access latency; asserts a pipeline stall while an access is in flight.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory (power of 2)
- LAT, 1, access latency in cycles (1..15); 1 = single-cycle access

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high reset
- mem_read_in  in  1  load request from EX/DM register
- mem_write_in  in  1  store request from EX/DM register
- mem_address_in  in  32  byte address (ALU result)
- write_data_in  in  32  store data
- mem_to_reg_in  in  1  writeback select, passed through
- reg_write_in  in  1  register-write enable, passed through
- rd_in  in  5  destination register, passed through
- read_data_out  out  32  load data to DM/WB
- alu_result_out  out  32  registered copy of mem_address_in
- rd_out  out  5  registered rd
- mem_to_reg_out  out  1  registered mem_to_reg
- reg_write_out  out  1  registered reg_write, gated as below
- stall_out  out  1  combinational; high while access outstanding; upstream holds inputs stable
- misalign_out  out  1  one-cycle pulse: misaligned access rejected

Behaviour:
- Reset: all outputs 0, FSM to IDLE, latency counter 0. Memory contents not cleared.
- Word index = mem_address_in[log2(DEPTH)+1:2]. Upper address bits ignored (wraps modulo DEPTH).
- FSM states: IDLE, WAIT.
- IDLE, no request (read=write=0):
  - next edge registers alu_result/rd/mem_to_reg/reg_write.
  - read_data_out=0.
- IDLE, request, LAT==1: access done at the next edge.
  - Store writes mem[idx].
  - Load registers mem[idx] into read_data_out.
  - Pass-through fields registered on the same edge.
- IDLE, request, LAT>1:
  - stall_out=1 combinationally in that cycle.
  - Go to WAIT with counter=LAT-2.
  - reg_write_out=0 (bubble) until completion.
- WAIT:
  - stall_out=1 while counter!=0; counter decrements each cycle.
  - When counter==0: stall_out=0; access performs at that edge, outputs registered, return to IDLE.
  - Total stall cycles = LAT-1.
- read and write both high: store performed, read_data_out=0.
- Misaligned (address[1:0]!=0) with a request:
  - No memory access; no stall.
  - misalign_out=1 for one cycle alongside the registered outputs.
  - reg_write_out forced 0.
- Load-after-store to the same address in consecutive accesses returns the new data.
- Reset during WAIT: access aborted, no memory write, outputs zeroed, IDLE next cycle.

Optional Feature:
- Macro: DM_TRACE_EN
- Defined: each completed access $displays time, R/W, byte address, data, rd.
- Undefined: no display code; RTL functionally identical either way.

Decomposition:
- Shared package (dm_pkg): DM_IDLE/DM_WAIT state encoding, WORD_BYTES=4, ADDR_LSB=2 constants, DEPTH/LAT defaults.
- One natural sub-module: dm_word_ram. Single-port synchronous word RAM: write enable, index, wdata, rdata, registered read.
- dm_stage_unit holds the FSM, latency counter and output registers.

Test Plan:
- Reset:
  - Stimulus: reset high 2 cycles with mem_write_in=1.
  - Response: all outputs 0, memory unchanged, stall_out=0.
- LAT=1 store/load:
  - Stimulus: store 0xDEADBEEF @0x10, then load @0x10 with rd=5, reg_write=1, mem_to_reg=1.
  - Response: next cycle read_data_out=0xDEADBEEF, rd_out=5, reg_write_out=1.
- LAT=4 load:
  - Stimulus: load @0x20, inputs held.
  - Response: stall_out high exactly 3 cycles, reg_write_out=0 during stall, data valid on the following edge.
- Misalign:
  - Stimulus: load @0x13 with reg_write=1.
  - Response: misalign_out pulse, reg_write_out=0, no stall, memory unchanged.
- Wrap, DEPTH=256:
  - Stimulus: store 0x1234 @0x400, then load @0x000.
  - Response: 0x1234.
- Reset in WAIT, LAT=4:
  - Stimulus: store 0x55 @0x8, reset asserted 1 cycle into stall, then load @0x8.
  - Response: old value returned, store aborted.
